// File: rtl/key_db_pkg.sv
// Shared types and width helpers for the key debouncer: hold-FSM state
// encoding and the $clog2-based counter sizing used by every channel.
package key_db_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT
   } hold_state_t;

   localparam int unsigned MIN_CNT_W = 1;

   // Width of a counter that must hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w < MIN_CNT_W) ? MIN_CNT_W : w;
   endfunction

endpackage

// File: rtl/key_db_chan.sv
// One key channel: two-flop synchronizer, stability counter that accepts a
// level change after DB_CYCLES differing cycles, and the long-press/repeat FSM.
module key_db_chan
   import key_db_pkg::*;
#(
   parameter int unsigned DB_CYCLES  = 262144,
   parameter int unsigned LP_CYCLES  = 33554432,
   parameter int unsigned RP_CYCLES  = 4194304,
   parameter int unsigned REPEAT_EN  = 1,
   parameter int unsigned ACTIVE_LOW = 1
)(
   input  logic cp,
   input  logic rst,
   input  logic key,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long,
   output logic key_repeat
);

   localparam int unsigned DB_W   = cnt_width(DB_CYCLES);
   localparam int unsigned HOLD_W = cnt_width(LP_CYCLES + 1);
   localparam int unsigned REP_W  = cnt_width(RP_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LP_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LP_CYCLES);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(RP_CYCLES - 1);

   localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

   logic              sync_meta;
   logic              sync_out;
   logic [DB_W-1:0]   db_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;
   hold_state_t       state;

   logic pressed;
   logic differs;
   logic accept;

   assign pressed = sync_out ^ RELEASED_RAW;
   assign differs = (pressed != key_level);
   assign accept  = differs && (db_cnt == DB_LAST);

   // An accepted release outranks the hold FSM, so a long or repeat pulse
   // falling on the release edge is dropped.
   always_ff @(posedge cp) begin
      if (!rst) begin
         sync_meta   <= RELEASED_RAW;
         sync_out    <= RELEASED_RAW;
         db_cnt      <= '0;
         hold_cnt    <= '0;
         rep_cnt     <= '0;
         state       <= ST_IDLE;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         sync_meta   <= key;
         sync_out    <= sync_meta;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;

         if (!differs) begin
            db_cnt <= '0;
         end else if (accept) begin
            db_cnt      <= '0;
            key_level   <= pressed;
            key_press   <= pressed;
            key_release <= !pressed;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end

         if (accept) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
            state    <= pressed ? ST_HOLD : ST_IDLE;
         end else begin
            case (state)
               ST_HOLD: begin
                  if (hold_cnt == HOLD_LAST) begin
                     key_long <= 1'b1;
                     hold_cnt <= HOLD_SAT;
                     if (REPEAT_EN != 0) begin
                        state   <= ST_REPEAT;
                        rep_cnt <= '0;
                     end
                  end else if (hold_cnt != HOLD_SAT) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt == REP_LAST) begin
                     key_repeat <= 1'b1;
                     rep_cnt    <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
               default: begin
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/key_debounce_n.sv
// N-channel key debouncer with press/release, long-press and auto-repeat
// pulses; every channel is an independent key_db_chan.
module key_debounce_n
   import key_db_pkg::*;
#(
   parameter int unsigned N          = 7,
   parameter int unsigned DB_CYCLES  = 262144,
   parameter int unsigned LP_CYCLES  = 33554432,
   parameter int unsigned RP_CYCLES  = 4194304,
   parameter int unsigned REPEAT_EN  = 1,
   parameter int unsigned ACTIVE_LOW = 1
)(
   input  logic         cp,
   input  logic         rst,
   input  logic [N-1:0] key,
   output logic [N-1:0] key_level,
   output logic [N-1:0] key_press,
   output logic [N-1:0] key_release,
   output logic [N-1:0] key_long,
   output logic [N-1:0] key_repeat
);

   for (genvar i = 0; i < N; i++) begin : g_chan
      key_db_chan #(
         .DB_CYCLES  (DB_CYCLES),
         .LP_CYCLES  (LP_CYCLES),
         .RP_CYCLES  (RP_CYCLES),
         .REPEAT_EN  (REPEAT_EN),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .cp          (cp),
         .rst         (rst),
         .key         (key[i]),
         .key_level   (key_level[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i]),
         .key_repeat  (key_repeat[i])
      );
   end

endmodule

// File: doc/key_debounce_n.md
KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 The block SHALL have parameter N, default 7, number of independent key channels (1..32).
REQ-002 The block SHALL have parameter DB_CYCLES, default 262144, number of stable cycles required to accept a level change (>=2).
REQ-003 The block SHALL have parameter LP_CYCLES, default 33554432, number of held cycles after an accepted press before the long-press pulse (>=1).
REQ-004 The block SHALL have parameter RP_CYCLES, default 4194304, auto-repeat period after long-press (>=1).
REQ-005 The block SHALL have parameter REPEAT_EN, default 1, where 1 enables auto-repeat pulses.
REQ-006 The block SHALL have parameter ACTIVE_LOW, default 1, where 1 means a key reads 0 when pressed.
REQ-007 The block SHALL have port cp, input, 1 bit: the single system clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-009 The block SHALL have port key, input, N bits: raw asynchronous key inputs.
REQ-010 The block SHALL have port key_level, output, N bits: debounced state, 1 = pressed, regardless of ACTIVE_LOW.
REQ-011 The block SHALL have port key_press, output, N bits: one-cycle pulse on an accepted press.
REQ-012 The block SHALL have port key_release, output, N bits: one-cycle pulse on an accepted release.
REQ-013 The block SHALL have port key_long, output, N bits: one-cycle pulse when a hold reaches LP_CYCLES.
REQ-014 The block SHALL have port key_repeat, output, N bits: one-cycle pulse every RP_CYCLES after key_long while the key is held.

Function
REQ-015 Each key bit SHALL pass through a 2-flop synchronizer and be normalised to pressed=1 (inverted when ACTIVE_LOW=1) before debouncing.
REQ-016 Each channel SHALL have its own stability counter, ceil(log2(DB_CYCLES)) bits wide; channels share no state.
REQ-017 The stability counter SHALL clear while the synchronized input equals key_level and SHALL increment each cycle it differs.
REQ-018 When the synchronized input has differed for DB_CYCLES consecutive cycles, key_level SHALL toggle on that edge and the counter SHALL clear.
REQ-019 Any single-cycle return to equality before DB_CYCLES (a glitch) SHALL clear the counter with no output change.
REQ-020 Raw-to-key_level latency for a clean edge SHALL be exactly 2+DB_CYCLES cycles.
REQ-021 key_press or key_release SHALL be registered and asserted for exactly one cycle, in the same cycle key_level first shows the new value.
REQ-022 Per channel, a hold FSM SHALL have states IDLE, HOLD and REPEAT.
REQ-023 On an accepted press, the hold FSM SHALL go IDLE->HOLD and clear the hold counter.
REQ-024 In HOLD, when the count reaches LP_CYCLES cycles after the key_press cycle, the block SHALL pulse key_long and go to REPEAT (REPEAT_EN=1) or park in HOLD without further pulses (REPEAT_EN=0).
REQ-025 In REPEAT, the block SHALL pulse key_repeat every RP_CYCLES cycles, the first pulse coming RP_CYCLES after key_long.
REQ-026 An accepted release in any state SHALL return the hold FSM to IDLE in the key_release cycle and suppress a long or repeat pulse due in that same cycle.
REQ-027 Hold and repeat counters SHALL never wrap; the hold counter SHALL saturate after key_long.
REQ-028 key_press and key_long SHALL never assert in the same cycle for one channel, and simultaneous events on different channels SHALL all be reported in the same cycle.

Reset
REQ-029 With rst=0 at a cp edge, all outputs SHALL be 0, all counters 0, all FSMs IDLE, and synchronizer flops SHALL hold the released level.
REQ-030 A reset during a press or hold SHALL discard it with no key_release pulse, and a key still held after reset SHALL be re-accepted as a new press after 2+DB_CYCLES cycles.

Structure
REQ-031 A shared package key_db_pkg SHALL hold the hold-FSM state enum and the counter-width helper constants derived via $clog2.
REQ-032 One sub-module, key_db_chan (one channel: synchronizer, stability counter, hold FSM), SHALL be instantiated N times by a generate loop.

Verification (N=4, DB_CYCLES=4, LP_CYCLES=10, RP_CYCLES=3, ACTIVE_LOW=1)
REQ-033 The bench SHALL drive key[0] 1->0 held -> key_level[0]=1 and key_press[0]=1 for one cycle, 6 cycles after the edge.
REQ-034 The bench SHALL drive key[1] low for 3 cycles then high -> no key_level, key_press or key_release activity.
REQ-035 The bench SHALL hold key[2] low 30 cycles -> key_long at 10 cycles after key_press, then key_repeat at +3, +6, ... until release, then one key_release.
REQ-036 The bench SHALL press key[0] and key[3] on the same cycle -> both key_press bits high in the same cycle.
REQ-037 The bench SHALL assert rst=0 for 1 cycle during a hold on key[2] -> all outputs 0 next cycle, no key_release, and key_press re-fires 6 cycles after rst rises.
REQ-038 The bench SHALL release key[2] exactly when key_long is due -> key_release only, no key_long.
